// File: rtl/micro_sequencer_if.sv
// Sequencing bus between the microcode controller and the micro-program counter.
// The master drives the microword fields; the slave returns the registered uPC and status flags.
interface micro_sequencer_if #(
  parameter int unsigned UPC_W = 8
);
  logic             i_stall;
  logic [1:0]       i_addr_ctl;
  logic [UPC_W-1:0] i_dispatch;
  logic [UPC_W-1:0] i_branch;
  logic             i_clr_illegal;
  logic [UPC_W-1:0] o_upc;
  logic             o_instr_done;
  logic [3:0]       o_cycle_cnt;
  logic             o_illegal;
  logic             o_wrap;

  modport master (
    output i_stall, i_addr_ctl, i_dispatch, i_branch, i_clr_illegal,
    input  o_upc, o_instr_done, o_cycle_cnt, o_illegal, o_wrap
  );

  modport slave (
    input  i_stall, i_addr_ctl, i_dispatch, i_branch, i_clr_illegal,
    output o_upc, o_instr_done, o_cycle_cnt, o_illegal, o_wrap
  );
endinterface

// File: rtl/micro_sequencer.sv
// Micro-program counter: selects the next MICRO_ROM address from the microword sequencing field,
// counts microcycles per instruction and keeps sticky illegal-dispatch and wrap flags.
module micro_sequencer #(
  parameter int unsigned          UPC_W        = 8,
  parameter logic [UPC_W-1:0]     FETCH_ADDR   = 8'h00,
  parameter logic [UPC_W-1:0]     TRAP_ADDR    = 8'hFE,
  parameter logic [UPC_W-1:0]     ILLEGAL_CODE = 8'hFF
) (
  input  logic              clk,
  input  logic              reset_n,
  micro_sequencer_if.slave  bus
);

  localparam logic [1:0] CTL_FETCH    = 2'b00;
  localparam logic [1:0] CTL_DISPATCH = 2'b01;
  localparam logic [1:0] CTL_NEXT     = 2'b10;
  localparam logic [1:0] CTL_BRANCH   = 2'b11;

  logic [UPC_W-1:0] upc_q, upc_d;
  logic             done_q, done_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ill_q, ill_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    upc_d  = upc_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    ill_d  = ill_q;
    wrap_d = wrap_q;
    if (!bus.i_stall) begin
      // Clear first so a same-edge illegal dispatch below overrides it.
      if (bus.i_clr_illegal) ill_d = 1'b0;
      cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
      case (bus.i_addr_ctl)
        CTL_FETCH: begin
          upc_d  = FETCH_ADDR;
          cnt_d  = '0;
          done_d = 1'b1;
        end
        CTL_DISPATCH: begin
          if (bus.i_dispatch == ILLEGAL_CODE) begin
            upc_d = TRAP_ADDR;
            ill_d = 1'b1;
          end else begin
            upc_d = bus.i_dispatch;
          end
        end
        CTL_NEXT: begin
          upc_d = upc_q + 1'b1;
          if (&upc_q) wrap_d = 1'b1;
        end
        CTL_BRANCH: upc_d = bus.i_branch;
        default:    upc_d = upc_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upc_q  <= FETCH_ADDR;
      done_q <= 1'b0;
      cnt_q  <= '0;
      ill_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      upc_q  <= upc_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      ill_q  <= ill_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.o_upc        = upc_q;
  assign bus.o_instr_done = done_q;
  assign bus.o_cycle_cnt  = cnt_q;
  assign bus.o_illegal    = ill_q;
  assign bus.o_wrap       = wrap_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: reset, R-type flow, illegal dispatch, stall, wrap/saturation, branch.
module tb_micro_sequencer;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  micro_sequencer_if #(.UPC_W(8)) bus ();

  micro_sequencer #(
    .UPC_W        (8),
    .FETCH_ADDR   (8'h00),
    .TRAP_ADDR    (8'hFE),
    .ILLEGAL_CODE (8'hFF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one microword, then sample 1 time unit after the rising edge.
  task automatic step(input logic [1:0] ctl, input logic [7:0] disp, input logic [7:0] br,
                      input logic stall, input logic clr);
    bus.i_addr_ctl    = ctl;
    bus.i_dispatch    = disp;
    bus.i_branch      = br;
    bus.i_stall       = stall;
    bus.i_clr_illegal = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [7:0] upc, input logic [3:0] cnt,
                           input logic done, input logic ill, input logic wrap);
    chk({tag, ".upc"},  {24'd0, bus.o_upc},       {24'd0, upc});
    chk({tag, ".cnt"},  {28'd0, bus.o_cycle_cnt}, {28'd0, cnt});
    chk({tag, ".done"}, {31'd0, bus.o_instr_done}, {31'd0, done});
    chk({tag, ".ill"},  {31'd0, bus.o_illegal},   {31'd0, ill});
    chk({tag, ".wrap"}, {31'd0, bus.o_wrap},      {31'd0, wrap});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    bus.i_stall = 1'b0; bus.i_addr_ctl = 2'b00; bus.i_dispatch = '0;
    bus.i_branch = '0;  bus.i_clr_illegal = 1'b0;

    // Reset held 3 cycles with random inputs
    for (int i = 0; i < 3; i++) begin
      step(2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    chk_state("reset", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    bus.i_stall = 1'b0; bus.i_clr_illegal = 1'b0; bus.i_addr_ctl = 2'b10;
    #2 reset_n = 1'b1;

    // R-type: next, dispatch 06, next, fetch
    step(2'b10, 8'h00, 8'h00, 1'b0, 1'b0); chk_state("rt1", 8'h01, 4'd1, 1'b0, 1'b0, 1'b0);
    step(2'b01, 8'h06, 8'h00, 1'b0, 1'b0); chk_state("rt2", 8'h06, 4'd2, 1'b0, 1'b0, 1'b0);
    step(2'b10, 8'h00, 8'h00, 1'b0, 1'b0); chk_state("rt3", 8'h07, 4'd3, 1'b0, 1'b0, 1'b0);
    step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0); chk_state("rt4", 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
    step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0); chk_state("b2b_fetch", 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
    step(2'b10, 8'h00, 8'h00, 1'b0, 1'b0); chk_state("after_fetch", 8'h01, 4'd1, 1'b0, 1'b0, 1'b0);

    // Illegal dispatch, set-wins, clear, dispatch to trap address directly
    step(2'b01, 8'hFF, 8'h00, 1'b0, 1'b0); chk_state("ill_set", 8'hFE, 4'd2, 1'b0, 1'b1, 1'b0);
    step(2'b01, 8'hFF, 8'h00, 1'b0, 1'b1); chk_state("ill_setwins", 8'hFE, 4'd3, 1'b0, 1'b1, 1'b0);
    step(2'b10, 8'h00, 8'h00, 1'b0, 1'b1); chk_state("ill_clr", 8'hFF, 4'd4, 1'b0, 1'b0, 1'b0);
    step(2'b01, 8'hFE, 8'h00, 1'b0, 1'b0); chk_state("disp_trap", 8'hFE, 4'd5, 1'b0, 1'b0, 1'b0);

    // Stall at upc=03, cnt=3 with fetch pending
    step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0); chk_state("st_fetch", 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(2'b10, 8'h00, 8'h00, 1'b0, 1'b0);
    chk_state("st_pre", 8'h03, 4'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
      chk_state("st_hold", 8'h03, 4'd3, 1'b0, 1'b0, 1'b0);
    end
    step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0); chk_state("st_release", 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);

    // Clear request ignored during stall
    step(2'b01, 8'hFF, 8'h00, 1'b0, 1'b0); chk_state("stclr_set", 8'hFE, 4'd1, 1'b0, 1'b1, 1'b0);
    step(2'b10, 8'h00, 8'h00, 1'b1, 1'b1); chk_state("stclr_hold", 8'hFE, 4'd1, 1'b0, 1'b1, 1'b0);
    step(2'b10, 8'h00, 8'h00, 1'b0, 1'b1); chk_state("stclr_clr", 8'hFF, 4'd2, 1'b0, 1'b0, 1'b0);

    // Wrap and saturation: branch to F0 then 20 next ops
    step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    step(2'b11, 8'h00, 8'hF0, 1'b0, 1'b0); chk_state("wr_br", 8'hF0, 4'd1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      logic [7:0] eu;
      logic [3:0] ec;
      eu = 8'(8'hF0 + k);
      ec = (k + 1 > 15) ? 4'd15 : 4'(k + 1);
      step(2'b10, 8'h00, 8'h00, 1'b0, 1'b0);
      chk("wr.upc",  {24'd0, bus.o_upc},       {24'd0, eu});
      chk("wr.cnt",  {28'd0, bus.o_cycle_cnt}, {28'd0, ec});
      chk("wr.wrap", {31'd0, bus.o_wrap},      {31'd0, (k >= 16)});
    end

    // Branch: no legality check, wrap stays sticky
    step(2'b11, 8'h00, 8'h2A, 1'b0, 1'b0); chk_state("br_2a", 8'h2A, 4'd15, 1'b0, 1'b0, 1'b1);
    step(2'b11, 8'h00, 8'hFF, 1'b0, 1'b0); chk_state("br_ff", 8'hFF, 4'd15, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle at upc=05
    step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(2'b10, 8'h00, 8'h00, 1'b0, 1'b0);
    chk_state("ar_pre", 8'h05, 4'd5, 1'b0, 1'b0, 1'b1);
    #2 reset_n = 1'b0;
    #1 chk_state("ar_async", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    step(2'b10, 8'h00, 8'h00, 1'b0, 1'b0); chk_state("ar_held", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
